// File: rtl/piano_pkg.sv
// Shared constants for the piano song player: song geometry, field widths and
// sequencer state encodings.
package piano_pkg;
  localparam int         SONG_LEN  = 26;
  localparam int         NOTE_W    = 4;
  localparam int         DUR_W     = 26;
  localparam int         LOC_W     = 5;
  localparam logic [1:0] SONG_NONE = 2'd0;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_LOAD  = 3'd2;
  localparam logic [2:0] S_PLAY  = 3'd3;
  localparam logic [2:0] S_GAP   = 3'd4;
endpackage

// File: rtl/song_sequencer_dur_counter.sv
// Loadable down-counter with zero flag; saturates at zero instead of wrapping.
module dur_counter #(
  parameter int W = 26
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_val,
  input  logic         i_en,
  output logic         o_zero
);
  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                        r_cnt <= '0;
    else if (i_load)                r_cnt <= i_val;
    else if (i_en && r_cnt != '0)   r_cnt <= r_cnt - W'(1);
  end

  assign o_zero = (r_cnt == '0);
endmodule

// File: rtl/song_sequencer.sv
// Auto-play sequencer: walks the song ROM, holds each note for its duration,
// inserts a silent gap, and loops or finishes at the end of the song.
module song_sequencer #(
  parameter int SONG_LEN   = piano_pkg::SONG_LEN,
  parameter int GAP_CYCLES = 5_000_000,
  parameter int DUR_W      = piano_pkg::DUR_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             pause,
  input  logic             loop_en,
  input  logic [1:0]       song_sel,
  output logic             mem_isread,
  output logic [1:0]       mem_songnum,
  output logic [4:0]       mem_location,
  input  logic [3:0]       mem_note,
  input  logic [DUR_W-1:0] mem_duration,
  output logic [3:0]       note_out,
  output logic             note_on,
  output logic             busy,
  output logic             done
);
  import piano_pkg::*;

  localparam logic [DUR_W-1:0] GAP_LD = (GAP_CYCLES > 0) ? DUR_W'(GAP_CYCLES - 1) : '0;

  logic [2:0]       r_state;
  logic [1:0]       r_song;
  logic [LOC_W-1:0] r_loc;
  logic [3:0]       r_note;
  logic             r_done;

  logic             w_start, w_last;
  logic             w_dur_zero, w_gap_zero;
  logic             w_dur_load, w_gap_load;
  logic [DUR_W-1:0] w_dur_val;
  logic [2:0]       w_adv_state;
  logic [LOC_W-1:0] w_adv_loc;
  logic             w_adv_done;

  assign w_start = start && (song_sel != SONG_NONE);
  assign w_last  = (r_loc == LOC_W'(SONG_LEN - 1));

  // Next location / state when the current note is finished or skipped
  always_comb begin
    w_adv_state = S_FETCH;
    w_adv_loc   = r_loc + LOC_W'(1);
    w_adv_done  = 1'b0;
    if (w_last) begin
      w_adv_loc = '0;
      if (!loop_en) begin
        w_adv_state = S_IDLE;
        w_adv_done  = 1'b1;
      end
    end
  end

  assign w_dur_load = (r_state == S_LOAD);
  assign w_dur_val  = (mem_duration == '0) ? '0 : mem_duration - DUR_W'(1);
  assign w_gap_load = (GAP_CYCLES != 0) && (r_state == S_PLAY) && !pause && w_dur_zero;

  dur_counter #(.W(DUR_W)) u_dur (
    .clk(clk), .rst(rst), .i_load(w_dur_load), .i_val(w_dur_val),
    .i_en((r_state == S_PLAY) && !pause), .o_zero(w_dur_zero)
  );

  dur_counter #(.W(DUR_W)) u_gap (
    .clk(clk), .rst(rst), .i_load(w_gap_load), .i_val(GAP_LD),
    .i_en((r_state == S_GAP) && !pause), .o_zero(w_gap_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_song  <= SONG_NONE;
      r_loc   <= '0;
      r_note  <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (stop) begin
        r_state <= S_IDLE;
        r_song  <= SONG_NONE;
        r_loc   <= '0;
        r_note  <= '0;
      end else if (w_start) begin
        r_state <= S_FETCH;
        r_song  <= song_sel;
        r_loc   <= '0;
      end else begin
        case (r_state)
          S_FETCH: r_state <= S_LOAD;
          S_LOAD: begin
            if (mem_duration == '0) begin
              r_state <= w_adv_state;
              r_loc   <= w_adv_loc;
              r_done  <= w_adv_done;
              if (w_adv_done) r_song <= SONG_NONE;
            end else begin
              r_note  <= mem_note;
              r_state <= S_PLAY;
            end
          end
          S_PLAY: begin
            if (!pause && w_dur_zero) begin
              if (GAP_CYCLES != 0) r_state <= S_GAP;
              else begin
                r_state <= w_adv_state;
                r_loc   <= w_adv_loc;
                r_done  <= w_adv_done;
                if (w_adv_done) r_song <= SONG_NONE;
              end
            end
          end
          S_GAP: begin
            if (!pause && w_gap_zero) begin
              r_state <= w_adv_state;
              r_loc   <= w_adv_loc;
              r_done  <= w_adv_done;
              if (w_adv_done) r_song <= SONG_NONE;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign mem_isread   = (r_state == S_FETCH);
  assign mem_songnum  = r_song;
  assign mem_location = r_loc;
  assign note_out     = r_note;
  assign note_on      = (r_state == S_PLAY) && !pause;
  assign busy         = (r_state != S_IDLE);
  assign done         = r_done;
endmodule

// File: tb/tb_song_sequencer.sv
// Scoreboard bench for song_sequencer: expected ROM reads and note runs are
// queued by the stimulus and consumed by a negedge monitor.
module tb_song_sequencer;
  localparam int DW  = 26;
  localparam int LEN = 26;

  logic          clk = 1'b0;
  logic          rst, start, stop, pause, loop_en;
  logic [1:0]    song_sel;
  logic          mem_isread, note_on, busy, done;
  logic [1:0]    mem_songnum;
  logic [4:0]    mem_location;
  logic [3:0]    mem_note = '0;
  logic [DW-1:0] mem_duration = '0;
  logic [3:0]    note_out;

  always #5 clk = ~clk;

  song_sequencer #(.SONG_LEN(LEN), .GAP_CYCLES(2), .DUR_W(DW)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .pause(pause),
    .loop_en(loop_en), .song_sel(song_sel), .mem_isread(mem_isread),
    .mem_songnum(mem_songnum), .mem_location(mem_location),
    .mem_note(mem_note), .mem_duration(mem_duration), .note_out(note_out),
    .note_on(note_on), .busy(busy), .done(done)
  );

  int rom_dur[LEN];

  function automatic int note_of(input int s, input int l);
    return (s * 5 + l) % 16;
  endfunction

  // ROM with exactly one cycle of read latency
  always @(posedge clk)
    if (mem_isread) begin
      mem_note     <= 4'(note_of(int'(mem_songnum), int'(mem_location)));
      mem_duration <= DW'(rom_dur[mem_location]);
    end

  typedef struct { int song; int loc; } fetch_t;
  typedef struct { int note; int len; int gap; } note_t;
  fetch_t exp_fetch[$];
  note_t  exp_note[$];

  int n_chk = 0, n_fail = 0, done_cycles = 0;
  int run = 0, off = 0, start_off = 0, cur_note = 0;
  fetch_t mf;
  note_t  mn;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic void push_fetch(input int s, input int l);
    fetch_t f;
    f.song = s; f.loc = l;
    exp_fetch.push_back(f);
  endfunction

  function automatic void push_note(input int s, input int l, input int len, input int gap);
    note_t n;
    n.note = note_of(s, l); n.len = len; n.gap = gap;
    exp_note.push_back(n);
  endfunction

  // Monitor: ROM reads, audible note runs (value, length, preceding silence), done pulses
  initial forever begin
    @(negedge clk);
    if (rst) begin
      run = 0; off = 0;
    end else begin
      if (done) done_cycles++;
      if (mem_isread) begin
        if (exp_fetch.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL fetch: unexpected read song %0d loc %0d", mem_songnum, mem_location);
        end else begin
          mf = exp_fetch.pop_front();
          check("fetch song", int'(mem_songnum), mf.song);
          check("fetch loc", int'(mem_location), mf.loc);
        end
      end
      if (note_on) begin
        if (run == 0) begin
          cur_note  = int'(note_out);
          start_off = off;
        end
        run++;
      end else begin
        if (run > 0) begin
          if (exp_note.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL note: unexpected note %0d len %0d", cur_note, run);
          end else begin
            mn = exp_note.pop_front();
            check("note value", cur_note, mn.note);
            check("note length", run, mn.len);
            if (mn.gap >= 0) check("silence before note", start_off, mn.gap);
          end
          run = 0; off = 0;
        end
        off++;
      end
    end
  end

  // kind: 0 note_on at loc, 1 ROM read, 2 not busy, 3 note_on low
  task automatic wait_for(input int kind, input int loc, input string name);
    bit ok = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      case (kind)
        0: ok = note_on && (int'(mem_location) == loc);
        1: ok = mem_isread;
        2: ok = !busy;
        default: ok = !note_on;
      endcase
      if (ok) break;
    end
    if (!ok) begin
      n_chk++; n_fail++;
      $display("FAIL timeout %s: got no event, expected event within 3000 cycles", name);
    end
  endtask

  task automatic pulse_start(input logic [1:0] s);
    @(posedge clk); #1 start = 1'b1; song_sel = s;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic check_queues(input string name);
    check({name, " fetch queue"}, exp_fetch.size(), 0);
    check({name, " note queue"}, exp_note.size(), 0);
  endtask

  initial begin
    for (int i = 0; i < LEN; i++) rom_dur[i] = 3 + (i * 5) % 6;
    rst = 1'b1; start = 1'b0; stop = 1'b0; pause = 1'b0; loop_en = 1'b0; song_sel = 2'd0;
    repeat (2) @(negedge clk);
    check("rst note_on", note_on, 0);
    check("rst busy", busy, 0);
    check("rst isread", mem_isread, 0);
    check("rst songnum", mem_songnum, 0);
    check("rst location", mem_location, 0);
    check("rst note_out", note_out, 0);
    check("rst done", done, 0);
    @(posedge clk); #1 rst = 1'b0;

    // start with no song selected
    pulse_start(2'd0);
    repeat (3) @(negedge clk);
    check("sel0 busy", busy, 0);
    check("sel0 isread", mem_isread, 0);

    // full song 1 with a 10-cycle pause three cycles into location 7 (duration 8)
    for (int l = 0; l < LEN; l++) begin
      push_fetch(1, l);
      if (l == 7) begin
        push_note(1, l, 3, 4);
        push_note(1, l, 5, 10);
      end else push_note(1, l, rom_dur[l], (l == 0) ? -1 : 4);
    end
    pulse_start(2'd1);
    wait_for(0, 7, "note loc7");
    @(negedge clk); @(negedge clk);
    @(posedge clk); #1 pause = 1'b1;
    repeat (10) @(posedge clk);
    #1 pause = 1'b0;
    wait_for(2, 0, "song1 end");
    @(negedge clk);
    check("song1 done pulses", done_cycles, 1);
    check("song1 songnum idle", mem_songnum, 0);
    check_queues("song1");

    // loop: after location 25 the next read is location 0, no done
    loop_en = 1'b1;
    for (int l = 0; l < LEN; l++) begin
      push_fetch(1, l);
      push_note(1, l, rom_dur[l], (l == 0) ? -1 : 4);
    end
    push_fetch(1, 0);
    pulse_start(2'd1);
    wait_for(0, 25, "loop note loc25");
    wait_for(1, 0, "loop refetch");
    check("loop busy", busy, 1);
    check("loop location", mem_location, 0);
    check("loop done pulses", done_cycles, 1);
    @(posedge clk); #1 stop = 1'b1;
    @(posedge clk); #1 stop = 1'b0; loop_en = 1'b0;
    @(negedge clk);
    check("loop stop busy", busy, 0);
    check_queues("loop");

    // stop during the fourth audible cycle of location 7
    for (int l = 0; l < 7; l++) begin
      push_fetch(2, l);
      push_note(2, l, rom_dur[l], (l == 0) ? -1 : 4);
    end
    push_fetch(2, 7);
    push_note(2, 7, 4, 4);
    pulse_start(2'd2);
    wait_for(0, 7, "stop note loc7");
    @(negedge clk); @(negedge clk);
    @(posedge clk); #1 stop = 1'b1;
    @(posedge clk); #1 stop = 1'b0;
    check("stop note_on", note_on, 0);
    check("stop isread", mem_isread, 0);
    check("stop busy", busy, 0);
    repeat (5) @(negedge clk);
    check("stop done pulses", done_cycles, 1);
    check_queues("stop");

    // song switch to 3 while song 2 plays location 10, then song 3 to completion
    for (int l = 0; l < 10; l++) begin
      push_fetch(2, l);
      push_note(2, l, rom_dur[l], (l == 0) ? -1 : 4);
    end
    push_fetch(2, 10);
    push_note(2, 10, 2, 4);
    for (int l = 0; l < LEN; l++) begin
      push_fetch(3, l);
      push_note(3, l, rom_dur[l], (l == 0) ? -1 : 4);
    end
    pulse_start(2'd2);
    wait_for(0, 10, "switch note loc10");
    pulse_start(2'd3);
    wait_for(2, 0, "song3 end");
    @(negedge clk);
    check("song3 done pulses", done_cycles, 2);
    check_queues("switch");

    // zero duration at location 4 is skipped; reset in the gap after location 5
    rom_dur[4] = 0;
    for (int l = 0; l < 6; l++) begin
      push_fetch(1, l);
      if (l != 4) push_note(1, l, rom_dur[l], (l == 0) ? -1 : ((l == 5) ? 6 : 4));
    end
    pulse_start(2'd1);
    wait_for(0, 5, "note loc5");
    wait_for(3, 0, "gap after loc5");
    #1 rst = 1'b1;
    #1;
    check("rstgap note_on", note_on, 0);
    check("rstgap busy", busy, 0);
    check("rstgap isread", mem_isread, 0);
    check("rstgap songnum", mem_songnum, 0);
    check("rstgap location", mem_location, 0);
    check("rstgap note_out", note_out, 0);
    @(posedge clk); #1 rst = 1'b0;
    rom_dur[4] = 3 + 20 % 6;
    repeat (3) @(negedge clk);
    check("rstgap done pulses", done_cycles, 2);
    check_queues("skip");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
